// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with up/down stepping, validated parallel load and
// a zero-latency carry strobe for chaining into the next stage's enable.
module bcd_mod_counter #(
    parameter int MODULUS = 60,
    parameter int HW      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic          inc_i,
    input  logic          dn_i,
    input  logic          ld_i,
    input  logic [HW-1:0] dh_i,
    input  logic [3:0]    dl_i,
    output logic [HW-1:0] qh_o,
    output logic [3:0]    ql_o,
    output logic          ca_o,
    output logic          lderr_o
);

    localparam logic [HW-1:0] MAX_H = HW'((MODULUS - 1) / 10);
    localparam logic [3:0]    MAX_L = 4'((MODULUS - 1) % 10);

    logic [HW-1:0] qh_q, qh_d;
    logic [3:0]    ql_q, ql_d;
    logic          lderr_q, lderr_d;
    logic          step;
    logic          at_max;
    logic          at_zero;
    logic          ld_legal;

    assign step    = en_i | inc_i;
    // Wrap is decided on the full two-digit value so non-decade moduli (e.g. 24) work.
    assign at_max  = (qh_q == MAX_H) && (ql_q == MAX_L);
    assign at_zero = (qh_q == '0) && (ql_q == 4'd0);
    assign ld_legal = (dl_i <= 4'd9) && ((int'(dh_i) * 10 + int'(dl_i)) < MODULUS);

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        qh_d    = qh_q;
        ql_d    = ql_q;
        lderr_d = 1'b0;
        if (clr_i) begin
            qh_d = '0;
            ql_d = 4'd0;
        end else if (ld_i) begin
            if (ld_legal) begin
                qh_d = dh_i;
                ql_d = dl_i;
            end else begin
                lderr_d = 1'b1;
            end
        end else if (step) begin
            if (!dn_i) begin
                if (at_max) begin
                    qh_d = '0;
                    ql_d = 4'd0;
                end else if (ql_q == 4'd9) begin
                    qh_d = qh_q + HW'(1);
                    ql_d = 4'd0;
                end else begin
                    ql_d = ql_q + 4'd1;
                end
            end else begin
                if (at_zero) begin
                    qh_d = MAX_H;
                    ql_d = MAX_L;
                end else if (ql_q == 4'd0) begin
                    qh_d = qh_q - HW'(1);
                    ql_d = 4'd9;
                end else begin
                    ql_d = ql_q - 4'd1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qh_q    <= '0;
            ql_q    <= 4'd0;
            lderr_q <= 1'b0;
        end else begin
            qh_q    <= qh_d;
            ql_q    <= ql_d;
            lderr_q <= lderr_d;
        end
    end

    assign ca_o    = step & ~clr_i & ~ld_i & ((~dn_i & at_max) | (dn_i & at_zero));
    assign qh_o    = qh_q;
    assign ql_o    = ql_q;
    assign lderr_o = lderr_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: a mod-60 and a mod-24 instance share stimulus,
// each scenario checks only the instance it targets.
module tb_bcd_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0, en = 1'b0, inc = 1'b0, dn = 1'b0, ld = 1'b0;
    logic [3:0] dh  = 4'd0;
    logic [3:0] dl  = 4'd0;

    logic [2:0] a_qh;
    logic [3:0] a_ql;
    logic       a_ca, a_lderr;
    logic [1:0] b_qh;
    logic [3:0] b_ql;
    logic       b_ca, b_lderr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_mod_counter #(.MODULUS(60), .HW(3)) u_m60 (
        .clk(clk), .rst(rst), .clr_i(clr), .en_i(en), .inc_i(inc), .dn_i(dn),
        .ld_i(ld), .dh_i(dh[2:0]), .dl_i(dl),
        .qh_o(a_qh), .ql_o(a_ql), .ca_o(a_ca), .lderr_o(a_lderr)
    );

    bcd_mod_counter #(.MODULUS(24), .HW(2)) u_m24 (
        .clk(clk), .rst(rst), .clr_i(clr), .en_i(en), .inc_i(inc), .dn_i(dn),
        .ld_i(ld), .dh_i(dh[1:0]), .dl_i(dl),
        .qh_o(b_qh), .ql_o(b_ql), .ca_o(b_ca), .lderr_o(b_lderr)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive a full input vector on the falling edge, then let combinational outputs settle.
    task automatic drive(input logic c, input logic l, input logic e, input logic i,
                         input logic d, input logic [3:0] h, input logic [3:0] u);
        @(negedge clk);
        clr = c; ld = l; en = e; inc = i; dn = d; dh = h; dl = u;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int va();
        return int'(a_qh) * 10 + int'(a_ql);
    endfunction

    function automatic int vb();
        return int'(b_qh) * 10 + int'(b_ql);
    endfunction

    initial begin
        #2;
        check("rst_a_v", va(), 0);
        check("rst_a_lderr", int'(a_lderr), 0);
        check("rst_b_v", vb(), 0);
        @(negedge clk);
        rst = 1'b0;

        // Count up through the mod-60 wrap.
        drive(0, 1, 0, 0, 0, 4'd5, 4'd8);
        tick();
        check("ld58_v", va(), 58);
        drive(0, 0, 1, 0, 0, 4'd0, 4'd0);
        check("ca_at58", int'(a_ca), 0);
        tick();
        check("up_59", va(), 59);
        #3;
        check("ca_at59", int'(a_ca), 1);
        tick();
        check("wrap_qh", int'(a_qh), 0);
        check("wrap_ql", int'(a_ql), 0);

        // Down wrap from 00 via manual step pulses.
        drive(0, 0, 0, 1, 1, 4'd0, 4'd0);
        check("ca_dn_at00", int'(a_ca), 1);
        tick();
        check("dn_wrap_qh", int'(a_qh), 5);
        check("dn_wrap_ql", int'(a_ql), 9);
        drive(0, 0, 0, 1, 1, 4'd0, 4'd0);
        check("ca_dn_at59", int'(a_ca), 0);
        tick();
        check("dn_58", va(), 58);

        // Legal load then step; EN and INC together give a single step.
        drive(0, 1, 0, 0, 0, 4'd4, 4'd5);
        tick();
        check("ld45_v", va(), 45);
        check("ld45_lderr", int'(a_lderr), 0);
        drive(0, 0, 1, 1, 0, 4'd0, 4'd0);
        tick();
        check("up_46", va(), 46);

        // Units borrow on down step: 40 -> 39.
        drive(0, 1, 0, 0, 0, 4'd4, 4'd0);
        tick();
        drive(0, 0, 1, 0, 1, 4'd0, 4'd0);
        tick();
        check("dn_borrow_39", va(), 39);

        // Illegal loads: value out of range, then non-BCD units digit.
        drive(0, 1, 0, 0, 0, 4'd6, 4'd1);
        tick();
        check("ld61_hold", va(), 39);
        check("ld61_lderr", int'(a_lderr), 1);
        drive(0, 0, 0, 0, 0, 4'd0, 4'd0);
        tick();
        check("ld61_lderr_clr", int'(a_lderr), 0);
        drive(0, 1, 0, 0, 0, 4'd2, 4'hA);
        tick();
        check("ld2A_hold", va(), 39);
        check("ld2A_lderr", int'(a_lderr), 1);
        drive(0, 0, 0, 0, 0, 4'd0, 4'd0);
        tick();
        check("ld2A_lderr_clr", int'(a_lderr), 0);
        check("idle_hold", va(), 39);

        // CLR beats LD and step, and suppresses CA.
        drive(0, 1, 0, 0, 0, 4'd5, 4'd9);
        tick();
        drive(1, 1, 1, 0, 0, 4'd1, 4'd1);
        check("clr_ca", int'(a_ca), 0);
        tick();
        check("clr_v", va(), 0);

        // Asynchronous reset mid-cycle while counting.
        drive(0, 0, 1, 0, 0, 4'd0, 4'd0);
        tick();
        tick();
        check("pre_rst_v", va(), 2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_v", va(), 0);
        check("async_rst_lderr", int'(a_lderr), 0);
        drive(0, 0, 0, 0, 0, 4'd0, 4'd0);
        rst = 1'b0;

        // Mod-24 instance: wrap compare on the full value.
        drive(0, 1, 0, 0, 0, 4'd2, 4'd3);
        tick();
        check("m24_ld23", vb(), 23);
        drive(0, 0, 1, 0, 0, 4'd0, 4'd0);
        check("m24_ca_up", int'(b_ca), 1);
        tick();
        check("m24_wrap", vb(), 0);
        drive(0, 0, 1, 0, 1, 4'd0, 4'd0);
        check("m24_ca_dn", int'(b_ca), 1);
        tick();
        check("m24_dn_23", vb(), 23);
        drive(0, 1, 0, 0, 0, 4'd2, 4'd4);
        tick();
        check("m24_ld24_hold", vb(), 23);
        check("m24_ld24_lderr", int'(b_lderr), 1);
        drive(0, 0, 1, 0, 0, 4'd0, 4'd0);
        tick();
        check("m24_lderr_clr", int'(b_lderr), 0);
        drive(0, 1, 0, 0, 0, 4'd0, 4'd9);
        tick();
        drive(0, 0, 1, 0, 0, 4'd0, 4'd0);
        tick();
        check("m24_carry_10", vb(), 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
